hilo_muldiv_ctrl: RTL
=====================

# hilo_muldiv_ctrl

Multi-cycle sequencer for unsigned multiply and divide (MULTU/DIVU) feeding the HI/LO register pair in the EX stage. It sits beside the ID/EX pipeline register. While an operation runs, it holds the pipeline frozen through a stall output that drives the `en_reg` enables upstream. The shift-add and restoring-divide iterations are executed one bit per cycle, and the 64-bit result is committed to HI/LO on completion.

## Interface
Parameters:
- `WIDTH`, 32, operand width; HI/LO are each `WIDTH` bits.
- `CNT_W`, 6, iteration counter width; must hold the value `WIDTH`.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: reset is synchronous and active-high.
- `start` in 1: the EX stage holds a valid instruction; sampled only in IDLE.
- `funct` in 6: the EX-stage funct field. MULTU = 6'h19, DIVU = 6'h1B; other codes are ignored.
- `op_a` in `WIDTH`: rs value (multiplicand / dividend).
- `op_b` in `WIDTH`: rt value (multiplier / divisor).
- `stall` out 1: high means upstream `en_reg` must be deasserted.
- `busy` out 1: high in MUL or DIV state.
- `done` out 1: one-cycle pulse; HI/LO hold the new result in the same cycle.
- `div_zero` out 1: one-cycle pulse with `done` when the divisor was 0.
- `hi` out `WIDTH`: HI register.
- `lo` out `WIDTH`: LO register.

## Operation
FSM states: IDLE, MUL, DIV, DONE.

**IDLE**
- If `start` and `funct`=MULTU:
  - `acc` ← {0, `op_b`}, `mcand` ← `op_a`, `cnt` ← 0.
  - Go to MUL.
- If `start` and `funct`=DIVU with `op_b`≠0:
  - `acc` ← {0, `op_a`}, `dvsr` ← `op_b`, `cnt` ← 0.
  - Go to DIV.
- If `start` and `funct`=DIVU with `op_b`=0:
  - `hi` ← `op_a`, `lo` ← all ones.
  - Set the `div_zero` flag.
  - Go to DONE.
- Otherwise remain in IDLE. `hi`/`lo` are unchanged.

**MUL** (each cycle)
- sum[WIDTH:0] = `acc`[2W-1:W] + (`acc`[0] ? `mcand` : 0).
- `acc` ← {sum, `acc`[W-1:1]} (33-bit sum, shift right by 1).
- `cnt`++.
- When `cnt`=W-1, load `hi`/`lo` from the next `acc` value and go to DONE.

**DIV** (restoring division, each cycle)
- t = {`acc`[2W-2:0], 0}.
- If t[2W-1:W] ≥ `dvsr`: upper half ← t[2W-1:W] − `dvsr`, and bit 0 ← 1.
- `acc` ← t (as modified).
- `cnt`++.
- When `cnt`=W-1: `hi` ← remainder (upper half), `lo` ← quotient (lower half), go to DONE.

**DONE**
- `done`=1.
- `div_zero` = flag.
- Always go to IDLE.
- `start` is ignored here. The finishing instruction is still in EX this cycle and must not retrigger.

**Outputs**
- `stall` = (IDLE & `start` & `funct`∈{MULTU,DIVU} & !divide-by-zero) | MUL | DIV. It is combinational from `start` in IDLE.
- `stall` is 0 in DONE, so the pipeline advances the same cycle `done` pulses.

**Reset** (`rst` high at posedge, any state, including mid-operation)
- state=IDLE, `cnt`=0, `acc`=0.
- `hi`=0, `lo`=0.
- `done`=0, `div_zero`=0, `busy`=0.
- A partial result is discarded and HI/LO are cleared.

Arithmetic is unsigned only. The 33-bit sum in MUL captures the carry.

## Timing
- `start` is accepted in cycle T.
- MUL/DIV occupy cycles T+1 … T+W (W cycles).
- DONE is cycle T+W+1. `hi`/`lo` are valid from T+W+1 onward.
- `stall` is high for cycles T … T+W (W+1 cycles), low at T+W+1.
- Divide-by-zero: `stall` stays low at T, DONE at T+1, `hi`/`lo` updated at T+1.
- MFHI/MFLO in the instruction following a mult/div reads the new values with no extra hazard.
- Back-to-back mult/div: the second op reaches EX at T+W+2 (IDLE) and is accepted then.

## Structure
- Shared package `muldiv_pkg`:
  - funct constants `FUNCT_MULTU`, `FUNCT_DIVU`.
  - State enum `muldiv_state_t` {IDLE, MUL, DIV, DONE}.
- Sub-module `muldiv_step`: combinational one-iteration datapath. Inputs: mode, `acc`, `mcand`/`dvsr`. Output: next `acc`.
- The FSM, counter and HI/LO registers live in the top module.

## Test plan
- MULTU `op_a`=32'hFFFFFFFF, `op_b`=32'hFFFFFFFF → `done` at T+33, `hi`=32'hFFFFFFFE, `lo`=32'h00000001, `stall` high exactly 33 cycles.
- DIVU `op_a`=100, `op_b`=7 → `hi`=2, `lo`=14 at T+33. DIVU `op_a`=5, `op_b`=9 → `hi`=5, `lo`=0.
- DIVU `op_b`=0, `op_a`=32'h1234 → `stall` never high, `done` and `div_zero` pulse at T+1, `hi`=32'h1234, `lo`=32'hFFFFFFFF.
- `start` with MULTU held high through DONE → no second operation; state IDLE at T+34, `busy`=0.
- `rst` asserted at T+10 of a MULTU → next cycle IDLE, `hi`=`lo`=0, `stall`=0, no `done` pulse.
- `start` with `funct`=6'h20 (ADD) → `stall`=0, `hi`/`lo` unchanged, `busy` stays 0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } muldiv_state_t;

   typedef enum logic {
      STEP_MUL = 1'b0,
      STEP_DIV = 1'b1
   } step_mode_t;

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// EX-stage request and HI/LO result bundle between the pipeline and the mul/div sequencer.
interface hilo_muldiv_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [5:0]       funct;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             stall;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, funct, op_a, op_b,
      input  stall, busy, done, div_zero, hi, lo
   );

   modport slave (
      input  start, funct, op_a, op_b,
      output stall, busy, done, div_zero, hi, lo
   );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on the double-width accumulator.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  step_mode_t         mode,
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   opnd,
   output logic [2*WIDTH-1:0] acc_next
);

   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   rem_s;
   logic [WIDTH-1:0] diff_s;

   // Next accumulator; the bit shifted out of the top still takes part in the divide compare.
   always_comb begin
      sum_s    = {1'b0, acc[2*WIDTH-1:WIDTH]}
               + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      rem_s    = acc[2*WIDTH-1:WIDTH-1];
      diff_s   = rem_s[WIDTH-1:0] - opnd;
      acc_next = {(2*WIDTH){1'b0}};
      case (mode)
         STEP_MUL: acc_next = {sum_s, acc[WIDTH-1:1]};
         STEP_DIV: begin
            if (rem_s >= {1'b0, opnd}) begin
               acc_next = {diff_s, acc[WIDTH-2:0], 1'b1};
            end else begin
               acc_next = {rem_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
         end
         default: acc_next = {(2*WIDTH){1'b0}};
      endcase
   end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle MULTU/DIVU sequencer: freezes the pipeline while iterating, then commits HI/LO.
module hilo_muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic               clk,
   input logic               rst,
   hilo_muldiv_ctrl_if.slave bus
);

   muldiv_state_t      state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               dz_q, dz_d;

   step_mode_t         step_mode_s;
   logic [2*WIDTH-1:0] acc_next_s;
   logic               is_mul_s;
   logic               is_div_s;
   logic               op_b_zero_s;
   logic               last_s;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .mode     (step_mode_s),
      .acc      (acc_q),
      .opnd     (opnd_q),
      .acc_next (acc_next_s)
   );

   // Next-state, counter, accumulator and HI/LO update.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      opnd_d      = opnd_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      dz_d        = dz_q;
      is_mul_s    = (bus.funct == FUNCT_MULTU);
      is_div_s    = (bus.funct == FUNCT_DIVU);
      op_b_zero_s = (bus.op_b == {WIDTH{1'b0}});
      last_s      = (cnt_q == CNT_W'(WIDTH - 1));
      step_mode_s = (state_q == DIV) ? STEP_DIV : STEP_MUL;
      case (state_q)
         IDLE: begin
            if (bus.start && is_mul_s) begin
               acc_d   = {{WIDTH{1'b0}}, bus.op_b};
               opnd_d  = bus.op_a;
               cnt_d   = {CNT_W{1'b0}};
               dz_d    = 1'b0;
               state_d = MUL;
            end else if (bus.start && is_div_s && !op_b_zero_s) begin
               acc_d   = {{WIDTH{1'b0}}, bus.op_a};
               opnd_d  = bus.op_b;
               cnt_d   = {CNT_W{1'b0}};
               dz_d    = 1'b0;
               state_d = DIV;
            end else if (bus.start && is_div_s) begin
               hi_d    = bus.op_a;
               lo_d    = {WIDTH{1'b1}};
               dz_d    = 1'b1;
               state_d = DONE;
            end else begin
               state_d = IDLE;
            end
         end
         MUL, DIV: begin
            acc_d = acc_next_s;
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (last_s) begin
               hi_d    = acc_next_s[2*WIDTH-1:WIDTH];
               lo_d    = acc_next_s[WIDTH-1:0];
               state_d = DONE;
            end else begin
               state_d = state_q;
            end
         end
         DONE: begin
            // The finishing instruction is still in EX here, so start must not retrigger.
            dz_d    = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: stall is combinational on start in IDLE; the rest come straight from flops.
   always_comb begin
      bus.stall    = ((state_q == IDLE) && bus.start
                      && (is_mul_s || (is_div_s && !op_b_zero_s)))
                   || (state_q == MUL) || (state_q == DIV);
      bus.busy     = (state_q == MUL) || (state_q == DIV);
      bus.done     = (state_q == DONE);
      bus.div_zero = (state_q == DONE) && dz_q;
      bus.hi       = hi_q;
      bus.lo       = lo_q;
   end

   // State registers with synchronous reset that discards any partial result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         acc_q   <= {(2*WIDTH){1'b0}};
         opnd_q  <= {WIDTH{1'b0}};
         hi_q    <= {WIDTH{1'b0}};
         lo_q    <= {WIDTH{1'b0}};
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dz_q    <= dz_d;
      end
   end

endmodule
